// File: rtl/soc_parameters.sv
// Shared SoC parameters for the scratchpad target: default geometry, the
// load FSM state encoding and the byte-mask expansion helper.
package soc_parameters;

    localparam int SCRATCHPAD_DEPTH   = 4096;
    localparam int SCRATCHPAD_LATENCY = 2;
    localparam int WORD_BITS          = 32;
    localparam int ADDR_BITS          = 32;
    localparam int MASK_BITS          = WORD_BITS / 8;

    typedef enum logic [1:0] {
        LOAD_IDLE    = 2'd0,
        LOAD_HOLD    = 2'd1,
        LOAD_READ    = 2'd2,
        LOAD_RESPOND = 2'd3
    } scratchpad_load_state_t;

    // Widen a per-byte enable into a per-bit write mask.
    function automatic logic [WORD_BITS-1:0] expand_mask(input logic [MASK_BITS-1:0] mask);
        logic [WORD_BITS-1:0] bits;
        bits = '0;
        for (int b = 0; b < MASK_BITS; b++) begin
            bits[8*b +: 8] = {8{mask[b]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/scratchpad_responder_if.sv
// CPU load/store channel pair as seen by a memory-side target; the CPU is
// the master, the responder is the slave.
interface scratchpad_responder_if;
    import soc_parameters::*;

    logic                 load_request_i;
    logic [ADDR_BITS-1:0] load_address_i;
    logic                 load_invalidate_i;
    logic [WORD_BITS-1:0] load_data_o;
    logic                 load_valid_o;
    logic                 store_request_i;
    logic [ADDR_BITS-1:0] store_address_i;
    logic [WORD_BITS-1:0] store_data_i;
    logic [MASK_BITS-1:0] store_mask_i;
    logic                 store_done_o;
    logic                 protocol_error_o;

    modport master (
        output load_request_i, load_address_i, load_invalidate_i,
        output store_request_i, store_address_i, store_data_i, store_mask_i,
        input  load_data_o, load_valid_o, store_done_o, protocol_error_o
    );

    modport slave (
        input  load_request_i, load_address_i, load_invalidate_i,
        input  store_request_i, store_address_i, store_data_i, store_mask_i,
        output load_data_o, load_valid_o, store_done_o, protocol_error_o
    );

endinterface

// File: rtl/scratchpad_ram.sv
// Single-port byte-writable scratchpad with a registered read port. The read
// register only updates on a read, so it holds the last word for the FSM.
module scratchpad_ram
    import soc_parameters::*;
#(
    parameter int DEPTH_WORDS = SCRATCHPAD_DEPTH,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [AW-1:0]        addr,
    input  logic [WORD_BITS-1:0] wdata,
    input  logic [MASK_BITS-1:0] wmask,
    output logic [WORD_BITS-1:0] rdata
);

    logic [WORD_BITS-1:0] mem_r [DEPTH_WORDS];
    logic [WORD_BITS-1:0] rdata_r;
    logic [WORD_BITS-1:0] bit_mask_s;

    assign bit_mask_s = expand_mask(wmask);
    assign rdata      = rdata_r;

    // Masked write; array contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_r[addr] <= (mem_r[addr] & ~bit_mask_s) | (wdata & bit_mask_s);
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_r <= {WORD_BITS{1'b0}};
        end else if (rd_en) begin
            rdata_r <= mem_r[addr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

endmodule

// File: rtl/scratchpad_responder.sv
// Leaf target terminating one CPU load channel and one store channel on the
// on-chip scratchpad: fixed-latency loads, one-cycle store acknowledge.
module scratchpad_responder
    import soc_parameters::*;
#(
    parameter int DEPTH_WORDS  = SCRATCHPAD_DEPTH,
    parameter int READ_LATENCY = SCRATCHPAD_LATENCY
) (
    input logic                   clk_i,
    input logic                   rst_n_i,
    scratchpad_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] READ_RELOAD =
        (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;
    localparam scratchpad_load_state_t ISSUE_STATE =
        (READ_LATENCY > 1) ? LOAD_READ : LOAD_RESPOND;

    scratchpad_load_state_t state_r;
    logic [3:0]             cnt_r;
    logic [AW-1:0]          addr_r;
    logic                   load_valid_r;
    logic                   store_done_r;
    logic                   error_r;

    logic [AW-1:0]          load_idx_s;
    logic [AW-1:0]          store_idx_s;
    logic [AW-1:0]          ram_addr_s;
    logic                   load_busy_s;
    logic                   load_accept_s;
    logic                   store_accept_s;
    logic                   ram_rd_s;
    logic [WORD_BITS-1:0]   ram_rdata_s;
    logic                   unused_addr_s;

    assign load_idx_s    = bus.load_address_i[AW+1:2];
    assign store_idx_s   = bus.store_address_i[AW+1:2];
    assign unused_addr_s = ^{bus.load_address_i[ADDR_BITS-1:AW+2], bus.load_address_i[1:0],
                             bus.store_address_i[ADDR_BITS-1:AW+2], bus.store_address_i[1:0]};

    assign load_busy_s    = (state_r == LOAD_HOLD) || (state_r == LOAD_READ);
    assign load_accept_s  = bus.load_request_i &&
                            (((state_r == LOAD_IDLE) && !bus.load_invalidate_i) ||
                             (state_r == LOAD_RESPOND));
    assign store_accept_s = bus.store_request_i && !store_done_r;
    // A store takes the port when it coincides with a load; HOLD reads one cycle later.
    assign ram_rd_s       = (load_accept_s && !store_accept_s) ||
                            ((state_r == LOAD_HOLD) && !bus.load_invalidate_i);

    // RAM port address: a store wins, a held load replays its latched index.
    always_comb begin
        ram_addr_s = {AW{1'b0}};
        if (store_accept_s) begin
            ram_addr_s = store_idx_s;
        end else if (state_r == LOAD_HOLD) begin
            ram_addr_s = addr_r;
        end else begin
            ram_addr_s = load_idx_s;
        end
    end

    scratchpad_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .rd_en   (ram_rd_s),
        .wr_en   (store_accept_s),
        .addr    (ram_addr_s),
        .wdata   (bus.store_data_i),
        .wmask   (bus.store_mask_i),
        .rdata   (ram_rdata_s)
    );

    // Load FSM with latency counter and registered valid strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= LOAD_IDLE;
            cnt_r        <= 4'd0;
            addr_r       <= {AW{1'b0}};
            load_valid_r <= 1'b0;
        end else begin
            load_valid_r <= 1'b0;
            case (state_r)
                LOAD_IDLE, LOAD_RESPOND: begin
                    if (load_accept_s) begin
                        addr_r <= load_idx_s;
                        if (store_accept_s) begin
                            state_r <= LOAD_HOLD;
                        end else begin
                            state_r      <= ISSUE_STATE;
                            cnt_r        <= READ_RELOAD;
                            load_valid_r <= (ISSUE_STATE == LOAD_RESPOND);
                        end
                    end else begin
                        state_r <= LOAD_IDLE;
                    end
                end
                LOAD_HOLD: begin
                    if (bus.load_invalidate_i) begin
                        state_r <= LOAD_IDLE;
                    end else begin
                        state_r      <= ISSUE_STATE;
                        cnt_r        <= READ_RELOAD;
                        load_valid_r <= (ISSUE_STATE == LOAD_RESPOND);
                    end
                end
                LOAD_READ: begin
                    if (bus.load_invalidate_i) begin
                        state_r <= LOAD_IDLE;
                    end else if (cnt_r == 4'd0) begin
                        state_r      <= LOAD_RESPOND;
                        load_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= LOAD_IDLE;
                end
            endcase
        end
    end

    // Store acknowledge doubles as the store-channel busy flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            store_done_r <= 1'b0;
        end else begin
            store_done_r <= store_accept_s;
        end
    end

    // Sticky protocol error for requests landing on a busy channel.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            error_r <= 1'b0;
        end else begin
            error_r <= error_r || (bus.load_request_i && load_busy_s) ||
                       (bus.store_request_i && store_done_r);
        end
    end

    assign bus.load_data_o      = ram_rdata_s;
    assign bus.load_valid_o     = load_valid_r;
    assign bus.store_done_o     = store_done_r;
    assign bus.protocol_error_o = error_r;

endmodule

// File: tb/tb_scratchpad_responder.sv
// Self-checking bench for scratchpad_responder: directed scenarios followed by
// random traffic, checked against a cycle-indexed transaction model.
module tb_scratchpad_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: word array plus the cycle each pending response is due.
    logic [31:0] mem_m [DEPTH];
    int          cyc = 0;
    bit          pend_m = 1'b0;
    int          due_m = 0;
    logic [31:0] exp_data_m = 32'd0;
    int          sdue_m = -1;
    logic        err_m = 1'b0;

    scratchpad_responder_if bus ();

    scratchpad_responder #(
        .DEPTH_WORDS  (DEPTH),
        .READ_LATENCY (LAT)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare the next cycle's outputs.
    task automatic tick(input logic lreq, input logic [31:0] laddr, input logic linv,
                        input logic sreq, input logic [31:0] saddr,
                        input logic [31:0] sdata, input logic [3:0] smask);
        bit lbusy;
        bit resp;
        bit sacc;
        bit exp_valid;
        int si;
        bus.load_request_i    = lreq;
        bus.load_address_i    = laddr;
        bus.load_invalidate_i = linv;
        bus.store_request_i   = sreq;
        bus.store_address_i   = saddr;
        bus.store_data_i      = sdata;
        bus.store_mask_i      = smask;

        lbusy = pend_m && (cyc < due_m);
        resp  = pend_m && (cyc == due_m);
        if (lbusy && linv) pend_m = 1'b0;
        sacc = sreq && (sdue_m != cyc);
        if (sreq && !sacc) err_m = 1'b1;
        if (sacc) begin
            si = int'(saddr[13:2]);
            for (int b = 0; b < 4; b++) begin
                if (smask[b]) mem_m[si][8*b +: 8] = sdata[8*b +: 8];
            end
            sdue_m = cyc + 1;
        end
        if (lreq) begin
            if (lbusy) begin
                err_m = 1'b1;
            end else if (!linv || resp) begin
                pend_m     = 1'b1;
                due_m      = cyc + LAT + (sacc ? 1 : 0);
                exp_data_m = mem_m[int'(laddr[13:2])];
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        exp_valid = pend_m && (due_m == cyc);
        check("load_valid", {31'd0, bus.load_valid_o}, {31'd0, exp_valid});
        if (exp_valid) check("load_data", bus.load_data_o, exp_data_m);
        check("store_done", {31'd0, bus.store_done_o}, {31'd0, (sdue_m == cyc)});
        check("protocol_error", {31'd0, bus.protocol_error_o}, {31'd0, err_m});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, bus.load_valid_o}, 32'd0);
        check({tag, "_data"}, bus.load_data_o, 32'd0);
        check({tag, "_done"}, {31'd0, bus.store_done_o}, 32'd0);
        check({tag, "_error"}, {31'd0, bus.protocol_error_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] la;
        logic [31:0] sa;
        bus.load_request_i    = 1'b0;
        bus.load_address_i    = 32'd0;
        bus.load_invalidate_i = 1'b0;
        bus.store_request_i   = 1'b0;
        bus.store_address_i   = 32'd0;
        bus.store_data_i      = 32'd0;
        bus.store_mask_i      = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Seed the words used below so every read has a known value.
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, 32'd0, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);
            idle(1);
        end

        // Full store then load at 0x10.
        tick(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        idle(1);
        tick(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        idle(1);
        check("deadbeef_valid", {31'd0, bus.load_valid_o}, 32'd1);
        check("deadbeef_data", bus.load_data_o, 32'hDEAD_BEEF);
        idle(2);

        // Byte-masked merge.
        tick(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0030, 32'h1122_3344, 4'hF);
        idle(1);
        tick(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0030, 32'h0000_00AA, 4'b0001);
        idle(1);
        tick(1'b1, 32'h0000_0030, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        idle(1);
        check("mask_merge", bus.load_data_o, 32'h1122_33AA);
        idle(2);

        // Zero mask leaves memory alone but still acknowledges.
        tick(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'b0000);
        check("zero_mask_done", {31'd0, bus.store_done_o}, 32'd1);
        idle(1);

        // Same-cycle store and load to one word: one extra cycle, post-store data.
        tick(1'b1, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF);
        idle(1);
        check("hold_not_yet", {31'd0, bus.load_valid_o}, 32'd0);
        idle(1);
        check("hold_valid", {31'd0, bus.load_valid_o}, 32'd1);
        check("hold_data", bus.load_data_o, 32'hCAFE_F00D);
        idle(2);

        // Invalidated load produces nothing; the next one works.
        tick(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        tick(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 4'h0);
        idle(10);
        tick(1'b1, 32'h0000_0044, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        idle(3);

        // Address wrap: 0x4004 aliases 0x0004.
        tick(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_4004, 32'h5A5A_1234, 4'hF);
        idle(1);
        tick(1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        idle(1);
        check("wrap_data", bus.load_data_o, 32'h5A5A_1234);
        idle(2);

        // Back-to-back load while busy: error, first completes, second dropped.
        tick(1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        tick(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        check("busy_error", {31'd0, bus.protocol_error_o}, 32'd1);
        check("busy_first_data", bus.load_data_o, 32'hDEAD_BEEF);
        idle(6);

        // Reset in the middle of a read aborts it.
        tick(1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h0000_0050, 32'h1234_5678, 4'hF);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        pend_m = 1'b0;
        sdue_m = -1;
        err_m  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = cyc + 1;
        idle(8);

        // Random traffic over the seeded words with aliasing upper bits.
        for (int n = 0; n < 400; n++) begin
            la = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            sa = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            tick(($urandom_range(0, 2) == 0), la, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0), sa, $urandom, 4'($urandom_range(0, 15)));
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
